// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential PC fetch into a 2-entry {pc, instr} FIFO
// with redirect flush, halt and a running fetch counter.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_DELAY = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic [31:0] fetch_count
);
    localparam int unused_imem_delay = IMEM_DELAY;

    logic [63:0] pc_q, pc_d, pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] in0_q, in0_d, in1_q, in1_d, fcnt_q, fcnt_d;
    logic [1:0]  count_q, count_d, widx;
    logic        pop, fetch;
    logic [1:0]  unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign imem_addr   = {2'b00, pc_q[63:2]};
    assign out_valid   = (count_q != 2'd0);
    assign out_instr   = out_valid ? in0_q : 32'h0;
    assign out_pc      = out_valid ? pc0_q : 64'h0;
    assign fetch_count = fcnt_q;
    assign pop   = out_valid & out_ready;
    assign fetch = ~halt & ~redirect_valid & ((count_q < 2'd2) | pop);
    // Entry 0 is always the head; a push lands in the slot left after any pop.
    assign widx  = count_q - {1'b0, pop};

    always_comb begin
        pc0_d = pop ? pc1_q : pc0_q;
        in0_d = pop ? in1_q : in0_q;
        pc1_d = pc1_q;
        in1_d = in1_q;
        if (fetch && widx == 2'd0) begin
            pc0_d = pc_q;
            in0_d = imem_instr;
        end
        if (fetch && widx == 2'd1) begin
            pc1_d = pc_q;
            in1_d = imem_instr;
        end
        count_d = redirect_valid ? 2'd0 : count_q + {1'b0, fetch} - {1'b0, pop};
        pc_d    = redirect_valid ? {redirect_pc[63:2], 2'b00} : fetch ? pc_q + 64'd4 : pc_q;
        fcnt_d  = fcnt_q + {31'b0, fetch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            pc0_q   <= 64'h0;
            pc1_q   <= 64'h0;
            in0_q   <= 32'h0;
            in1_q   <= 32'h0;
            count_q <= 2'd0;
            fcnt_q  <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
        end
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, byte address loaded into PC on reset.
REQ-002 Parameter: IMEM_DELAY, default 50, simulation-only annotation matching the instruction memory read delay; no functional effect.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: imem_addr  output  64  word index to instruction memory, {2'b00, pc[63:2]}.
REQ-006 Port: imem_instr  input  32  instruction word returned combinationally by memory for imem_addr.
REQ-007 Port: redirect_valid  input  1  branch/exception redirect request.
REQ-008 Port: redirect_pc  input  64  byte address of redirect target.
REQ-009 Port: halt  input  1  suspends new fetches while high.
REQ-010 Port: out_valid  output  1  head entry available to decode.
REQ-011 Port: out_ready  input  1  decode accepts head entry.
REQ-012 Port: out_instr  output  32  instruction of head entry.
REQ-013 Port: out_pc  output  64  byte PC of head entry.
REQ-014 Port: fetch_count  output  32  number of instructions pushed since reset.

Function
REQ-015 Internal state: 64-bit pc register, 2-entry FIFO of {pc, instr}, 2-bit occupancy count (0..2), fetch_count.
REQ-016 imem_addr derives combinationally from the pc register only; it changes only after a clock edge.
REQ-017 pop = out_valid & out_ready; out_valid = (count != 0).
REQ-018 fetch = ~halt & ~redirect_valid & ((count < 2) | pop).
REQ-019 On fetch: push {pc, imem_instr} at FIFO tail, pc <= pc + 4 (modulo 2^64, wrap to 0 with no error), fetch_count <= fetch_count + 1 (wraps at 2^32).
REQ-020 Simultaneous push and pop with count==2 is legal; count remains 2, order preserved.
REQ-021 Simultaneous push and pop with count==1: count stays 1, pushed entry becomes head next cycle.
REQ-022 Pop with no push decrements count; push with no pop increments count; count never exceeds 2 or goes below 0.
REQ-023 When out_valid=1 and out_ready=0, out_instr and out_pc hold stable until pop.
REQ-024 When count==0, out_instr = 32'h0 and out_pc = 64'h0.
REQ-025 redirect_valid=1: next cycle count=0, pc = {redirect_pc[63:2], 2'b00}; no push that cycle; a same-cycle pop is considered consumed; redirect overrides halt.
REQ-026 Latency: an instruction fetched in cycle N is visible on out_instr with out_valid=1 in cycle N+1 if FIFO was empty.
REQ-027 Throughput: one instruction per cycle sustained while out_ready=1 and halt=0.
REQ-028 halt=1 with no redirect: pc frozen, FIFO drains via pops only.

Reset
REQ-029 rst_n=0 asynchronously sets pc=RESET_PC, count=0, fetch_count=0, out_valid=0, out_instr=0, out_pc=0.
REQ-030 Reset asserted mid-operation discards all FIFO entries and any pending redirect.
REQ-031 First fetch occurs on first rising edge with rst_n=1 and halt=0; imem_addr = RESET_PC>>2 during that cycle.

Verification
REQ-032 Memory words 0..3 = 8B1F03E5, F84000A4, 8B040086, F80010A6, RESET_PC=0, out_ready=1 -> out_instr sequence 8B1F03E5, F84000A4, 8B040086, F80010A6 on consecutive cycles with out_pc 0,4,8,12; fetch_count=4 after 4 fetches.
REQ-033 Same memory, out_ready=0 for 5 cycles -> count saturates at 2, pc=8, out_instr holds 8B1F03E5; release out_ready -> F84000A4 next, no loss or duplication.
REQ-034 Redirect to redirect_pc=64'h0B while count=2 -> next cycle out_valid=0, imem_addr=2; following cycle out_instr=8B040086, out_pc=8.
REQ-035 halt=1 with count=1 and out_ready=1 -> FIFO drains to empty, pc unchanged, fetch_count unchanged.
REQ-036 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch uses imem_addr=0 (pc wrap); rst_n pulsed low mid-stream -> out_valid=0 immediately, fetch_count=0.
